// File: rtl/blk_07b2ef_pkg.sv
// Shared constants for the two-level carry look-ahead adder.
// Group width, default operand width and the derived group count live here.
package blk_07b2ef_pkg;

    localparam int CLA_GROUP     = 4;
    localparam int DEFAULT_WIDTH = 4;

    function automatic int num_groups(input int width);
        return width / CLA_GROUP;
    endfunction

    localparam int DEFAULT_NUM_GROUPS = num_groups(DEFAULT_WIDTH);

endpackage

// File: rtl/blk_07b2ef_cla_group4.sv
// Combinational 4-bit carry look-ahead group.
// Internal carries are flat sum-of-products; group generate/propagate feed the upper level.
module cla_group4
    import blk_07b2ef_pkg::*;
(
    input  logic [CLA_GROUP-1:0] a,
    input  logic [CLA_GROUP-1:0] b,
    input  logic                 c_in,
    output logic [CLA_GROUP-1:0] sum,
    output logic                 g,
    output logic                 p
);

    logic [CLA_GROUP-1:0] gen_s;
    logic [CLA_GROUP-1:0] prop_s;
    logic [CLA_GROUP-1:0] carry_s;

    assign gen_s  = a & b;
    assign prop_s = a ^ b;

    // Each carry is a two-level SOP of g, p and the group carry-in; no ripple chain.
    assign carry_s[0] = c_in;
    assign carry_s[1] = gen_s[0] | (prop_s[0] & c_in);
    assign carry_s[2] = gen_s[1] | (prop_s[1] & gen_s[0]) | (prop_s[1] & prop_s[0] & c_in);
    assign carry_s[3] = gen_s[2] | (prop_s[2] & gen_s[1]) | (prop_s[2] & prop_s[1] & gen_s[0])
                      | (prop_s[2] & prop_s[1] & prop_s[0] & c_in);

    assign sum = prop_s ^ carry_s;
    assign g   = gen_s[3] | (prop_s[3] & gen_s[2]) | (prop_s[3] & prop_s[2] & gen_s[1])
               | (prop_s[3] & prop_s[2] & prop_s[1] & gen_s[0]);
    assign p   = &prop_s;

endmodule

// File: rtl/blk_07b2ef.sv
// Registered WIDTH-bit adder built from 4-bit look-ahead groups and a second
// look-ahead level that computes every group carry directly from G, P and cin.
module blk_07b2ef
    import blk_07b2ef_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             cout,
    output logic [WIDTH-1:0] sum,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin
);

    localparam int NGRP = num_groups(WIDTH);

    logic [NGRP-1:0]           grp_g_s;
    logic [NGRP-1:0]           grp_p_s;
    logic [NGRP:0]             grp_c_s;
    logic [NGRP:0]             gen_ext_s;
    logic [NGRP-1:0][NGRP:0]   term_s;
    logic [WIDTH-1:0]          sum_s;
    logic [WIDTH-1:0]          sum_r;
    logic                      cout_r;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        cla_group4 u_grp (
            .a    (a[CLA_GROUP*k +: CLA_GROUP]),
            .b    (b[CLA_GROUP*k +: CLA_GROUP]),
            .c_in (grp_c_s[k]),
            .sum  (sum_s[CLA_GROUP*k +: CLA_GROUP]),
            .g    (grp_g_s[k]),
            .p    (grp_p_s[k])
        );
    end

    // Entry 0 is cin, entry j is G of group j-1, so carry k+1 = OR_j (gen_ext[j] & P[j..k]).
    assign gen_ext_s = {grp_g_s, cin};
    assign grp_c_s[0] = cin;

    for (genvar k = 0; k < NGRP; k++) begin : g_carry
        for (genvar j = 0; j <= NGRP; j++) begin : g_term
            if (j == k + 1) begin : g_last
                assign term_s[k][j] = gen_ext_s[j];
            end else if (j <= k) begin : g_mid
                assign term_s[k][j] = gen_ext_s[j] & (&grp_p_s[k:j]);
            end else begin : g_none
                assign term_s[k][j] = 1'b0;
            end
        end
        assign grp_c_s[k+1] = |term_s[k];
    end

    // Output register; reset clears immediately and drops any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
        end else begin
            sum_r  <= sum_s;
            cout_r <= grp_c_s[NGRP];
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_blk_07b2ef.sv
// Self-checking bench: directed table and reset sequences, exhaustive 4-bit sweep,
// random 16-bit vectors, all compared against plain integer addition.
module tb_blk_07b2ef;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  a4, b4, sum4;
    logic        cin4, cout4;
    logic [15:0] a16, b16, sum16;
    logic        cin16, cout16;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t tbl [5];

    blk_07b2ef #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .cout(cout4), .sum(sum4), .a(a4), .b(b4), .cin(cin4)
    );

    blk_07b2ef #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .cout(cout16), .sum(sum16), .a(a16), .b(b16), .cin(cin16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        logic [4:0]  exp4;
        logic [4:0]  prev4;
        logic [16:0] exp16;
        logic [8:0]  v;

        tbl[0] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[1] = '{4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0};
        tbl[2] = '{4'b0111, 4'b0111, 1'b0, 4'b1110, 1'b0};
        tbl[3] = '{4'b1011, 4'b1011, 1'b0, 4'b0110, 1'b1};
        tbl[4] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};

        // Reset held with arbitrary inputs, across a clock edge.
        rst_n = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'b1;
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'b1;
        #3;
        chk("reset_sum4", {28'd0, sum4}, 32'd0);
        chk("reset_cout4", {31'd0, cout4}, 32'd0);
        @(posedge clk); #1;
        chk("reset_hold_sum4", {28'd0, sum4}, 32'd0);
        chk("reset_hold_sum16", {16'd0, sum16}, 32'd0);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 5; i++) begin
            a4 = tbl[i].a; b4 = tbl[i].b; cin4 = tbl[i].cin;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_sum", i), {28'd0, sum4}, {28'd0, tbl[i].exp_sum});
            chk($sformatf("tbl%0d_cout", i), {31'd0, cout4}, {31'd0, tbl[i].exp_cout});
        end

        // Mid-stream asynchronous reset between edges clears at once and drops the pending op.
        a4 = 4'b0101; b4 = 4'b0110; cin4 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_clr_sum4", {28'd0, sum4}, 32'd0);
        chk("async_clr_cout4", {31'd0, cout4}, 32'd0);
        @(posedge clk); #1;
        chk("discard_sum4", {28'd0, sum4}, 32'd0);

        // First edge after release captures a fresh result.
        a4 = 4'b0011; b4 = 4'b0100; cin4 = 1'b1;
        a16 = 16'hffff; b16 = 16'hffff; cin16 = 1'b1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_sum4", {28'd0, sum4}, 32'h8);
        chk("post_rst_cout4", {31'd0, cout4}, 32'd0);
        chk("max16_sum", {16'd0, sum16}, 32'hffff);
        chk("max16_cout", {31'd0, cout16}, 32'd1);
        prev4 = 5'b01000;

        // Exhaustive 4-bit sweep alongside random 16-bit vectors.
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            a4 = v[7:4]; b4 = v[3:0]; cin4 = v[8];
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
            #2;
            chk("hold_between_edges4", {27'd0, cout4, sum4}, {27'd0, prev4});
            exp4  = 5'(a4) + 5'(b4) + 5'(cin4);
            exp16 = 17'(a16) + 17'(b16) + 17'(cin16);
            @(posedge clk); #1;
            chk($sformatf("sweep4_%0d", i), {27'd0, cout4, sum4}, {27'd0, exp4});
            chk("rand16", {15'd0, cout16, sum16}, {15'd0, exp16});
            prev4 = exp4;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/blk_07b2ef.md
NAME -- requirements
Module: name

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the operand and sum width in bits; legal values are positive multiples of 4.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-004 Port cout, output, 1 bit, SHALL be the registered carry-out of the addition.
REQ-005 Port sum, output, WIDTH bits, SHALL be the registered sum of the addition.
REQ-006 Port a, input, WIDTH bits, SHALL be operand A (unsigned).
REQ-007 Port b, input, WIDTH bits, SHALL be operand B (unsigned).
REQ-008 Port cin, input, 1 bit, SHALL be the carry-in.
REQ-009 The functional port order after clk and rst_n SHALL be cout, sum, a, b, cin, so that positional instantiation matches.

Function
REQ-010 The block SHALL compute {cout, sum} = a + b + cin as an unsigned WIDTH+1-bit result with no truncation.
REQ-011 The adder SHALL use carry look-ahead, not ripple carry:
- per-bit generate g[i] = a[i] & b[i]
- per-bit propagate p[i] = a[i] ^ b[i]
- carries within each 4-bit group from g, p and the group carry-in, as two-level sum-of-products
REQ-012 Each 4-bit group SHALL produce group generate G and group propagate P. A second look-ahead level SHALL derive the inter-group carries from G, P and cin, so that no carry ripples through more than one group.
REQ-013 Sum bit i SHALL equal p[i] ^ c[i], where c[0] = cin; cout SHALL equal the carry out of the MSB.
REQ-014 Latency: a, b and cin SHALL be sampled on the rising edge of clk, and the result SHALL appear on sum/cout one cycle after sampling. There is no handshake; a new operation is accepted every cycle.
REQ-015 Boundary: all-ones + all-ones + 1 SHALL give sum = all-ones and cout = 1. Zero + zero + 0 SHALL give sum = 0 and cout = 0. There is no overflow flag.
REQ-016 Outputs SHALL change only on a clk rising edge or on reset assertion, and SHALL be glitch-free between edges.

Reset
REQ-017 While rst_n = 0, sum SHALL be 0 and cout SHALL be 0, immediately and independent of clk.
REQ-018 A reset asserted mid-stream SHALL discard the pending result.
REQ-019 After rst_n deasserts, the first rising edge of clk SHALL capture a new result.

Structure
REQ-020 A shared package SHALL hold:
- CLA_GROUP = 4 (group width)
- the default WIDTH
- any group-count constant derived from WIDTH
REQ-021 One sub-module, cla_group4, SHALL implement a combinational 4-bit look-ahead group:
- inputs: a, b, c_in
- outputs: sum, G, P
REQ-022 The top level SHALL instantiate WIDTH/4 instances of cla_group4, implement the second-level carry logic, and hold the output register.

Verification
REQ-023 Reset: hold rst_n = 0 with any inputs -> sum = 0000, cout = 0; release rst_n, apply a = 0000, b = 0000, cin = 0 -> sum = 0000, cout = 0 after one clock.
REQ-024 Apply a = 0001, b = 0001, cin = 0 -> sum = 0010, cout = 0 one clock later.
REQ-025 Apply a = 0111, b = 0111, cin = 0 -> sum = 1110, cout = 0 one clock later.
REQ-026 Apply a = 1011, b = 1011, cin = 0 -> sum = 0110, cout = 1 one clock later.
REQ-027 Apply a = 1111, b = 1111, cin = 1 -> sum = 1111, cout = 1 one clock later. Then assert rst_n = 0 between edges -> outputs clear to 0 at once.
REQ-028 Exhaustive sweep of all 512 (a, b, cin) combinations at WIDTH = 4, plus random vectors at WIDTH = 16 -> {cout, sum} SHALL equal a + b + cin one cycle after each input.
